// File: rtl/mx_block_dot_seq.sv
// mx_block_dot_seq: block sequencer for the MX integer dot-product path.
// Accepts BLOCK_LEN products (in_valid/in_ready), aligns each one against the
// base exponent latched in CLEAR, accumulates into a 20-bit wrapping sum and
// presents the sum plus sat/uflow stickies on out_valid/out_ready.

module mx_int_aligner #(
  parameter int unsigned ACC_W = 20
) (
  input  logic [7:0]              mant,
  input  logic [7:0]              shift_amount,
  input  logic                    prod_sign,
  output logic signed [ACC_W-1:0] aligned
);
  logic [ACC_W-1:0] mag;

  always_comb begin
    mag     = ACC_W'(mant) << shift_amount;
    aligned = prod_sign ? -mag : mag;
  end
endmodule

module mx_int_acc #(
  parameter int unsigned ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] addend,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    acc_d = clear ? '0 : acc_q + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

module mx_block_dot_seq #(
  parameter int unsigned BLOCK_LEN = 32,
  parameter int unsigned MAX_SHIFT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         base_exp,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_mant,
  input  logic [7:0]         in_exp,
  input  logic               in_sign,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [19:0] out_acc,
  output logic               out_sat,
  output logic               out_uflow
);
  localparam int unsigned     CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam logic [7:0]       MAX_SH   = 8'(MAX_SHIFT);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       base_q, base_d;
  logic             sat_q, sat_d;
  logic             uflow_q, uflow_d;

  logic [8:0]       diff;
  logic             acc_clear;
  logic [7:0]       al_mant;
  logic [7:0]       al_shift;
  logic             al_sign;
  logic signed [19:0] al_value;
  logic signed [19:0] acc_value;

  // The accumulator adds every non-clear cycle, so the aligner is fed zero
  // except on an accepting handshake with an in-range shift.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    sat_d     = sat_q;
    uflow_d   = uflow_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clear = 1'b0;
    al_mant   = '0;
    al_shift  = '0;
    al_sign   = 1'b0;
    diff      = {1'b0, in_exp} - {1'b0, base_q};

    case (state_q)
      S_CLEAR: begin
        acc_clear = 1'b1;
        base_d    = base_exp;
        cnt_d     = '0;
        sat_d     = 1'b0;
        uflow_d   = 1'b0;
        state_d   = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (diff[8]) begin
            uflow_d = 1'b1;
          end else if (diff[7:0] > MAX_SH) begin
            sat_d = 1'b1;
          end else begin
            al_mant  = in_mant;
            al_shift = diff[7:0];
            al_sign  = in_sign;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      base_q  <= '0;
      sat_q   <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      sat_q   <= sat_d;
      uflow_q <= uflow_d;
    end
  end

  mx_int_aligner #(.ACC_W(20)) u_aligner (
    .mant         (al_mant),
    .shift_amount (al_shift),
    .prod_sign    (al_sign),
    .aligned      (al_value)
  );

  mx_int_acc #(.ACC_W(20)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .addend (al_value),
    .acc    (acc_value)
  );

  assign out_acc   = acc_value;
  assign out_sat   = sat_q;
  assign out_uflow = uflow_q;
endmodule
